// File: rtl/dbus_sram_responder_pkg.sv
// Shared definitions for the data-bus SRAM responder: bus structs, FSM state codes
// and the latency limit that sizes the response counter.
package dbus_sram_responder_pkg;

  localparam int DBUS_MAX_LATENCY = 15;
  localparam int DBUS_CNT_W       = $clog2(DBUS_MAX_LATENCY + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addrOk;
    logic        dataOk;
    logic [31:0] data;
  } dbus_resp_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/dbus_sram_responder_word_ram.sv
// Word-organised RAM: combinational read port, clocked write port with four byte enables.
// Contents have no reset; they survive a responder reset.
module dbus_word_ram #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [IW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus slave: accepts one request at a time with addr_ok and completes it with a
// single-cycle data_ok exactly LATENCY cycles later, backed by a word RAM.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dreqValid,
  input  logic [31:0] i_dreqAddr,
  input  logic [1:0]  i_dreqSize,
  input  logic [3:0]  i_dreqStrobe,
  input  logic [31:0] i_dreqData,
  input  logic        i_acceptEn,
  output logic        o_drespAddrOk,
  output logic        o_drespDataOk,
  output logic [31:0] o_drespData,
  output logic        o_busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [DBUS_CNT_W-1:0] CNT_LOAD = DBUS_CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > DBUS_MAX_LATENCY) begin : g_latencyCheck
    $error("dbus_sram_responder: LATENCY must be in 1..%0d", DBUS_MAX_LATENCY);
  end

  logic [1:0]            r_state;
  logic [DBUS_CNT_W-1:0] r_cnt;
  dbus_req_t             r_req;
  logic                  r_isWrite;

  logic                  w_accept;
  logic                  w_resp;
  logic                  w_we;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // Outputs are suppressed while reset is asserted so an aborted write never commits.
  assign w_accept = (r_state == S_IDLE) & i_dreqValid & i_acceptEn & ~i_reset;
  assign w_resp   = (r_state == S_RESP) & ~i_reset;
  assign w_we     = w_resp & r_isWrite;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_req     <= '0;
      r_isWrite <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req     <= '{valid: 1'b1, addr: i_dreqAddr, size: i_dreqSize,
                           strobe: i_dreqStrobe, data: i_dreqData};
            r_isWrite <= (i_dreqStrobe != 4'b0000);
            r_cnt     <= CNT_LOAD;
            r_state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == DBUS_CNT_W'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  dbus_word_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_be    (r_req.strobe),
    .i_waddr (r_req.addr[IW+1:2]),
    .i_wdata (r_req.data),
    .i_raddr (r_req.addr[IW+1:2]),
    .o_rdata (w_rdata)
  );

  assign o_drespAddrOk = w_accept;
  assign o_drespDataOk = w_resp;
  assign o_drespData   = (w_resp & ~r_isWrite) ? w_rdata : 32'h0;
  assign o_busy        = (r_state != S_IDLE);

  // Size is informational and the upper address bits alias; they are latched but unused.
  assign w_unused = ^{r_req.valid, r_req.size, r_req.addr[31:IW+2], r_req.addr[1:0]};

endmodule
